// File: rtl/ysyx_22050078_div_seq_pkg.sv
// Shared divider definitions: op-code layout, op encodings and FSM states.
package ysyx_22050078_div_seq_pkg;

  localparam int DIVOP_WIDTH   = 3;
  localparam int DIVOP_U_BIT   = 0;
  localparam int DIVOP_REM_BIT = 1;
  localparam int DIVOP_W_BIT   = 2;

  localparam logic [DIVOP_WIDTH-1:0] DIVOP_DIV   = 3'b000;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_DIVU  = 3'b001;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_REM   = 3'b010;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_REMU  = 3'b011;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_DIVW  = 3'b100;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_DIVUW = 3'b101;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_REMW  = 3'b110;
  localparam logic [DIVOP_WIDTH-1:0] DIVOP_REMUW = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/ysyx_22050078_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module ysyx_22050078_div_step
  import ysyx_22050078_div_seq_pkg::*;
#(
  parameter int CPU_WIDTH = 64
) (
  input  logic [CPU_WIDTH-1:0] rem,
  input  logic                 dvd_bit,
  input  logic [CPU_WIDTH-1:0] dvsr,
  output logic [CPU_WIDTH-1:0] rem_nxt,
  output logic                 q_bit
);

  logic [CPU_WIDTH:0]   shifted;
  logic [CPU_WIDTH+1:0] diff;

  // Trial subtraction; the extra top bit of diff is the borrow.
  always_comb begin
    shifted = {rem, dvd_bit};
    diff    = {1'b0, shifted} - {2'b00, dvsr};
    q_bit   = ~diff[CPU_WIDTH+1];
    rem_nxt = q_bit ? diff[CPU_WIDTH-1:0] : shifted[CPU_WIDTH-1:0];
  end

endmodule

// File: rtl/ysyx_22050078_div_seq.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU and their W forms).
// Magnitudes are divided one bit per cycle; signs are applied in FIXUP.
module ysyx_22050078_div_seq
  import ysyx_22050078_div_seq_pkg::*;
#(
  parameter int CPU_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DIVOP_WIDTH-1:0] i_divop,
  input  logic [CPU_WIDTH-1:0]   i_src1,
  input  logic [CPU_WIDTH-1:0]   i_src2,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_res_ready,
  output logic [CPU_WIDTH-1:0]   o_res,
  output logic                   o_busy
);

  localparam int CNT_W = $clog2(CPU_WIDTH + 1);

  function automatic logic [CPU_WIDTH-1:0] sext_w(input logic [CPU_WIDTH-1:0] v);
    return {{(CPU_WIDTH-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [CPU_WIDTH-1:0] zext_w(input logic [CPU_WIDTH-1:0] v);
    return {{(CPU_WIDTH-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [CPU_WIDTH-1:0] cond_neg(input logic [CPU_WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? -v : v;
  endfunction

  div_state_e state, state_nxt;

  logic                 op_w, op_rem, op_uns;
  logic signed [CPU_WIDTH-1:0] ext1, ext2;
  logic [CPU_WIDTH-1:0] abs1, abs2, min_val, spec_res;
  logic                 sgn1, sgn2, div_zero, ovf, special, accept;

  logic                 op_w_r, op_rem_r, neg_q_r, neg_r_r;
  logic [CPU_WIDTH-1:0] dvd_r, rem_r, dvsr_r, res_r, step_rem, fix_res;
  logic                 step_q;
  logic [CNT_W-1:0]     cnt_r;

  assign accept  = i_valid && o_ready && !i_flush;
  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);
  assign o_res   = res_r;

  // Operand decode: width/sign extension, magnitudes and special cases.
  always_comb begin
    op_w    = i_divop[DIVOP_W_BIT];
    op_rem  = i_divop[DIVOP_REM_BIT];
    op_uns  = i_divop[DIVOP_U_BIT];
    ext1    = op_w ? (op_uns ? zext_w(i_src1) : sext_w(i_src1)) : i_src1;
    ext2    = op_w ? (op_uns ? zext_w(i_src2) : sext_w(i_src2)) : i_src2;
    sgn1    = !op_uns && ext1[CPU_WIDTH-1];
    sgn2    = !op_uns && ext2[CPU_WIDTH-1];
    abs1    = sgn1 ? -ext1 : ext1;
    abs2    = sgn2 ? -ext2 : ext2;
    min_val = op_w ? {{(CPU_WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(CPU_WIDTH-1){1'b0}}};
    div_zero = (ext2 == '0);
    ovf      = !op_uns && (ext1 == min_val) && (ext2 == '1);
    special  = div_zero || ovf;
    // Results are sign-extended from bit 31 for W ops, unsigned ones included.
    if (div_zero)
      spec_res = op_rem ? (op_w ? sext_w(ext1) : ext1) : '1;
    else
      spec_res = op_rem ? '0 : (op_w ? sext_w(ext1) : ext1);
  end

  ysyx_22050078_div_step #(.CPU_WIDTH(CPU_WIDTH)) u_step (
    .rem     (rem_r),
    .dvd_bit (dvd_r[CPU_WIDTH-1]),
    .dvsr    (dvsr_r),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  // Sign correction of the raw quotient/remainder magnitudes.
  always_comb begin
    fix_res = op_rem_r ? cond_neg(rem_r, neg_r_r) : cond_neg(dvd_r, neg_q_r);
    if (op_w_r)
      fix_res = sext_w(fix_res);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt_r == CNT_W'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // Datapath: latch operands on accept, shift-subtract in CALC, result in FIXUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_w_r   <= 1'b0;
      op_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dvd_r    <= '0;
      rem_r    <= '0;
      dvsr_r   <= '0;
      res_r    <= '0;
      cnt_r    <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_w_r   <= op_w;
          op_rem_r <= op_rem;
          neg_q_r  <= sgn1 ^ sgn2;
          neg_r_r  <= sgn1;
          // W magnitudes sit in the top half so 32 steps consume them.
          dvd_r    <= op_w ? {abs1[31:0], {(CPU_WIDTH-32){1'b0}}} : abs1;
          rem_r    <= '0;
          dvsr_r   <= abs2;
          cnt_r    <= op_w ? CNT_W'(32) : CNT_W'(CPU_WIDTH);
          if (special) res_r <= spec_res;
        end
        CALC: begin
          dvd_r <= {dvd_r[CPU_WIDTH-2:0], step_q};
          rem_r <= step_rem;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        FIXUP:   res_r <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_div_seq.sv
// Scoreboard bench for the sequential divider: directed vectors push expected
// results and arrival cycles; a monitor checks each result as it appears.
module tb_ysyx_22050078_div_seq;
  import ysyx_22050078_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_res_ready = 1'b1;
  logic [2:0]  i_divop = '0;
  logic [63:0] i_src1 = '0;
  logic [63:0] i_src2 = '0;
  logic        o_ready, o_valid, o_busy;
  logic [63:0] o_res;

  ysyx_22050078_div_seq #(.CPU_WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_divop     (i_divop),
    .i_src1      (i_src1),
    .i_src2      (i_src2),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_res_ready (i_res_ready),
    .o_res       (o_res),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          vec_id = 0;
  logic        in_done = 1'b0;
  logic [63:0] held = '0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: first valid cycle pops the scoreboard, later valid cycles must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid) begin
        if (!in_done) begin
          in_done = 1'b1;
          held    = o_res;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got %h at cycle %0d, expected no result", o_res, cyc);
          end else begin
            e = exp_q.pop_front();
            check64($sformatf("vec%0d_res", e.id), o_res, e.res);
            check64($sformatf("vec%0d_cycle", e.id), 64'(cyc), 64'(e.due));
          end
        end else begin
          check64("hold_res", o_res, held);
          check64("hold_ready", {63'b0, o_ready}, 64'd0);
        end
      end else begin
        in_done = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!(o_ready && !o_valid && exp_q.size() == 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drive one request for a cycle; lat is cycles from accept edge to valid.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int lat, input bit push);
    @(negedge clk);
    i_divop = op;
    i_src1  = a;
    i_src2  = b;
    i_valid = 1'b1;
    if (push) exp_q.push_back('{exp_res, cyc + lat, vec_id});
    vec_id++;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp_res, input int lat);
    wait_idle();
    issue(op, a, b, exp_res, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    #1;
    check64("reset_valid", {63'b0, o_valid}, 64'd0);
    check64("reset_busy",  {63'b0, o_busy},  64'd0);
    check64("reset_ready", {63'b0, o_ready}, 64'd1);
    check64("reset_res",   o_res,            64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(DIVOP_DIV,   -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66);
    run(DIVOP_REM,   -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66);
    run(DIVOP_DIVU,  64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
    run(DIVOP_REMU,  64'd5, 64'd0, 64'd5, 1);
    run(DIVOP_DIVW,  64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
    run(DIVOP_DIV,   64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
    run(DIVOP_REM,   64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1);
    run(DIVOP_DIVW,  64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1);
    run(DIVOP_DIVUW, 64'h00000000FFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 34);
    run(DIVOP_REMW,  64'h12345678FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 34);
    run(DIVOP_DIV,   64'd20, -64'sd3, 64'hFFFFFFFFFFFFFFFA, 66);
    run(DIVOP_REM,   64'd20, -64'sd3, 64'd2, 66);
    run(DIVOP_REMU,  64'd100, 64'd7, 64'd2, 66);
    run(DIVOP_REMUW, 64'hABCD0000FFFFFFFF, 64'h10, 64'hF, 34);
    run(DIVOP_DIVUW, 64'h0000000080000000, 64'd1, 64'hFFFFFFFF80000000, 34);

    // Backpressure: result must hold in DONE until the consumer takes it.
    wait_idle();
    i_res_ready = 1'b0;
    issue(DIVOP_DIVU, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1);
    repeat (5) @(negedge clk);
    check64("bp_valid_held", {63'b0, o_valid}, 64'd1);
    i_res_ready = 1'b1;
    @(negedge clk);
    check64("bp_valid_after", {63'b0, o_valid}, 64'd0);
    check64("bp_ready_after", {63'b0, o_ready}, 64'd1);

    // Flush on the 10th CALC cycle: no result may ever appear.
    wait_idle();
    issue(DIVOP_DIVU, 64'd100, 64'd7, 64'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    check64("calc_busy",  {63'b0, o_busy},  64'd1);
    check64("calc_ready", {63'b0, o_ready}, 64'd0);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check64("flush_ready", {63'b0, o_ready}, 64'd1);
    check64("flush_valid", {63'b0, o_valid}, 64'd0);
    repeat (80) @(negedge clk);
    run(DIVOP_DIVU, 64'd100, 64'd7, 64'd14, 66);

    // Reset pulse mid-CALC: outputs return to reset values, no result later.
    issue(DIVOP_DIVU, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check64("rst_valid", {63'b0, o_valid}, 64'd0);
    check64("rst_busy",  {63'b0, o_busy},  64'd0);
    check64("rst_ready", {63'b0, o_ready}, 64'd1);
    check64("rst_res",   o_res,            64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    run(DIVOP_DIV, -64'sd100, 64'd7, 64'hFFFFFFFFFFFFFFF2, 66);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_22050078_div_seq.md
YSYX_22050078_DIV_SEQ -- requirements
Module: ysyx_22050078_div_seq

Interface
REQ-001 Parameter: CPU_WIDTH, default 64, datapath width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  divide request from the execute stage.
REQ-005 o_ready  output  1  request can be accepted; high only in IDLE.
REQ-006 i_divop  input  3  op code: bit2 = W (32-bit), bit1 = REM, bit0 = unsigned.
REQ-007 i_src1  input  CPU_WIDTH  dividend.
REQ-008 i_src2  input  CPU_WIDTH  divisor.
REQ-009 i_flush  input  1  kill the in-flight operation.
REQ-010 o_valid  output  1  o_res is valid.
REQ-011 i_res_ready  input  1  consumer takes the result.
REQ-012 o_res  output  CPU_WIDTH  quotient or remainder.
REQ-013 o_busy  output  1  pipeline stall request; high in every state except IDLE.

Function
REQ-014 Accept SHALL occur when i_valid && o_ready && !i_flush; op, operand signs and absolute values are latched on that edge.
REQ-015 States SHALL be IDLE, CALC, FIXUP and DONE.
- IDLE->CALC on a normal accept.
- IDLE->DONE on a special-case accept.
- CALC->FIXUP when the counter expires.
- FIXUP->DONE.
- DONE->IDLE when i_res_ready is high.
REQ-016 CALC SHALL run restoring shift-subtract at one quotient bit per cycle: 64 cycles for non-W ops, 32 for W ops; a down-counter tracks the remaining bits.
REQ-017 Latency from the accept edge t:
- o_valid first high at t+66 for non-W ops.
- o_valid first high at t+34 for W ops.
- o_valid first high at t+1 for special cases.
REQ-018 W ops SHALL use operand bits [31:0] only: sign-extended if signed, zero-extended if unsigned. The 32-bit result is sign-extended from bit 31, including DIVUW/REMUW.
REQ-019 FIXUP SHALL apply signed corrections:
- quotient negated when the operand signs differ;
- remainder takes the dividend's sign.
REQ-020 Divisor zero SHALL go directly to DONE with result: quotient all-ones (per width, then sign-extended), remainder = dividend (per width, sign-extended).
REQ-021 Signed overflow (dividend = most-negative value at the op width, divisor = -1) SHALL go directly to DONE with result: quotient = dividend, remainder = 0.
REQ-022 In DONE, o_valid and o_res SHALL hold stable until i_res_ready is high.
REQ-023 Handoff in DONE: o_ready stays low, so a new request is never accepted in the same cycle as the result handoff.
REQ-024 i_flush SHALL take priority in every state: next state IDLE, o_valid low next cycle, no result delivered. If i_flush is high in IDLE with i_valid high, the request is not accepted.
REQ-025 If i_flush and i_res_ready are both high in DONE, the state SHALL return to IDLE; the handoff is considered void.

Reset
REQ-026 On rst_n low, asynchronously:
- state = IDLE;
- o_valid = 0, o_busy = 0, o_ready = 1;
- o_res = 0, counter = 0, internal operand registers = 0.
REQ-027 Reset asserted mid-CALC SHALL abandon the operation; no result appears after rst_n deasserts.

Structure
REQ-028 The DIVOP encodings, DIVOP_WIDTH (3) and the state encoding SHALL be defined in the shared defines file next to the EXU_* opcodes.
REQ-029 One sub-module, ysyx_22050078_div_step, SHALL hold the combinational single-bit restoring step (partial remainder, divisor -> next remainder and quotient bit); the state machine, counter and fixup stay in the top module.

Verification
REQ-030 DIV, src1 = -7, src2 = 2, accept at t -> o_valid at t+66, o_res = 0xFFFFFFFFFFFFFFFD; REM with the same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-031 Divide by zero:
- DIVU 5/0 -> o_res = 0xFFFFFFFFFFFFFFFF at t+1.
- REMU 5/0 -> o_res = 5 at t+1.
- DIVW 5/0 -> o_res = 0xFFFFFFFFFFFFFFFF.
REQ-032 Signed overflow:
- DIV 0x8000000000000000 / -1 -> o_res = 0x8000000000000000 at t+1; REM -> 0.
- DIVW 0x80000000 / 0xFFFFFFFF -> o_res = 0xFFFFFFFF80000000.
REQ-033 DIVUW src1 = 0x00000000FFFFFFFF, src2 = 1 -> o_res = 0xFFFFFFFFFFFFFFFF at t+34; REMW src1 = 0x12345678_FFFFFFF9, src2 = 2 -> o_res = 0xFFFFFFFFFFFFFFFF.
REQ-034 Backpressure: i_res_ready held low for 5 cycles in DONE -> o_valid and o_res stable, o_ready low; the result is taken on the first i_res_ready-high edge, then IDLE.
REQ-035 Flush and reset:
- i_flush on the 10th CALC cycle -> IDLE next cycle, o_ready = 1, o_valid never asserted; a following DIVU 100/7 returns 14 at +66.
- rst_n pulsed mid-CALC -> all outputs at reset values.
